id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Registered ID/EX pipeline stage of the 16-bit CPU. It decodes the R-type fields of the issued instruction and captures operand data from the register file. It hands a stable operand/control bundle to the execute stage (shifter/ALU) through a valid/ready handshake. A two-entry skid buffer keeps full throughput when the execute stage stalls.

## Interface
Parameters:
- DATA_W, 16, operand width
- REG_AW, 2, register address width

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset; single clock domain
- InValid  in  1  decode stage presents an instruction
- InReady  out  1  stage can accept this cycle
- Instr  in  16  instruction word
- RsData  in  16  register file data for rs
- RtData  in  16  register file data for rt
- Flush  in  1  discard all held entries (branch/jump redirect)
- OutValid  out  1  bundle on Ex* is valid
- OutReady  in  1  execute stage consumes bundle
- ExA  out  16  rs operand (shifter input A)
- ExB  out  16  rt operand
- ExShamt  out  4  shift amount
- ExFunct  out  2  function code
- ExOp  out  4  opcode
- ExRd  out  2  destination register
- ExRegWrite  out  1  result must be written back
- ExIsShift  out  1  selects the SLL unit

## Operation
- Instruction fields: opcode = Instr[15:12], rs = Instr[11:10], rt = Instr[9:8], rd = Instr[7:6], shamt = Instr[5:2], funct = Instr[1:0].
- Decode:
  - ExIsShift = (opcode == 4'b0000) && (funct == 2'b00).
  - ExRegWrite = (opcode == 4'b0000) && (rd != 0). R0 is hardwired zero, so writes to it are suppressed here.
- Handshake events: accept = InValid & InReady; release = OutValid & OutReady.
- Storage: main entry (drives Ex*) and skid entry. Each entry holds {A, B, shamt, funct, op, rd, regwrite, isshift}.
- State machine:
  - EMPTY: accept → load main, go to ONE.
  - ONE, accept only → load skid, go to FULL.
  - ONE, release only → go to EMPTY.
  - ONE, accept and release → load main with the new instruction, stay in ONE.
  - FULL: release → copy skid into main, go to ONE. No accept is possible (InReady = 0).
- OutValid = (state != EMPTY). InReady = (state != FULL). Both come directly from state registers, with no combinational path from OutReady to InReady.
- Flush: next state is EMPTY regardless of other inputs. An instruction presented in the same cycle is dropped even if InValid = 1. Entry payloads may keep stale values; OutValid = 0 marks them invalid.
- Payload registers load only on their load enables. While OutValid = 1 and OutReady = 0, Ex* must not change.
- No arithmetic; widths pass through unchanged. Shamt stays 4 bits (0–15) and is not range-checked.

## Timing
- Reset (Reset = 0 at a clock edge):
  - state = EMPTY, OutValid = 0, InReady = 1.
  - All Ex* outputs = 0.
- Reset takes priority over Flush and over any handshake. Reset asserted mid-transfer loses both entries.
- Latency: accept in cycle N → OutValid = 1 with the bundle in cycle N+1 (from EMPTY).
- Throughput: 1 bundle/cycle while OutReady = 1.
- Stall: one OutReady = 0 cycle absorbs one extra instruction into skid. InReady drops in the following cycle.
- Ordering: strictly in order. Skid content is always newer than main.

## Structure
- Shared package cpu16_pkg:
  - field positions and widths (OPC, RS, RT, RD, SHAMT, FUNCT)
  - OPC_RTYPE = 4'b0000 and FUNCT_SLL = 2'b00
  - state encoding (EMPTY, ONE, FULL)
  - entry bundle struct
- One sub-module, id_ex_decode: purely combinational, Instr → {shamt, funct, op, rd, regwrite, isshift}. Instantiated once at the input.

## Test plan
- Reset: hold Reset = 0 for 2 cycles, then release → OutValid = 0, InReady = 1, all Ex* = 0.
- Single SLL: Instr = 16'h0014 (rs = 0, rd = 0, shamt = 5, funct = 0), RsData = 16'h0003, OutReady = 1 → next cycle OutValid = 1, ExA = 16'h0003, ExShamt = 5, ExIsShift = 1, ExRegWrite = 0 (rd = 0).
- Back-to-back: 4 instructions with rd = 1, shamt = 1..4 and OutReady = 1 → 4 consecutive OutValid cycles in order, ExRegWrite = 1, InReady constantly 1.
- Stall: OutReady = 0 while sending 3 instructions → first two captured and InReady = 0 after the second. Raise OutReady → bundles 1 and 2 emerge in order; the third is accepted once InReady returns to 1.
- Flush: state FULL, assert Flush together with InValid = 1 → next cycle OutValid = 0 and InReady = 1. The flushed and concurrent instructions never appear.
- Mid-operation reset: state FULL, Reset = 0 for 1 cycle → EMPTY, all Ex* = 0, no stale bundle emitted afterwards.

Source files
------------

// File: rtl/cpu16_pkg.sv
// rtl/cpu16_pkg.sv - shared 16-bit CPU field layout, decode constants, ID/EX state and entry types
package cpu16_pkg;

  // Datapath widths of the 16-bit core.
  localparam int CPU_DATA_W = 16;
  localparam int CPU_REG_AW = 2;
  localparam int INSTR_W    = 16;

  // R-type instruction field positions (lsb) and widths.
  localparam int OPC_LSB   = 12;
  localparam int OPC_W     = 4;
  localparam int RS_LSB    = 10;
  localparam int RS_W      = 2;
  localparam int RT_LSB    = 8;
  localparam int RT_W      = 2;
  localparam int RD_LSB    = 6;
  localparam int RD_W      = 2;
  localparam int SHAMT_LSB = 2;
  localparam int SHAMT_W   = 4;
  localparam int FUNCT_LSB = 0;
  localparam int FUNCT_W   = 2;

  // Opcode/funct values that select the register-register shift path.
  localparam logic [OPC_W-1:0]   OPC_RTYPE = 4'b0000;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL = 2'b00;

  // Occupancy of the two-entry ID/EX buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  // Control fields produced by the decoder.
  typedef struct packed {
    logic [SHAMT_W-1:0]    shamt;
    logic [FUNCT_W-1:0]    funct;
    logic [OPC_W-1:0]      op;
    logic [CPU_REG_AW-1:0] rd;
    logic                  regwrite;
    logic                  isshift;
  } ctrl_t;

  // One held bundle: operands plus decoded control.
  typedef struct packed {
    logic [CPU_DATA_W-1:0] a;
    logic [CPU_DATA_W-1:0] b;
    ctrl_t                 ctrl;
  } entry_t;

  // Builds an entry from operand data and decoded control.
  function automatic entry_t make_entry(input logic [CPU_DATA_W-1:0] a,
                                        input logic [CPU_DATA_W-1:0] b,
                                        input ctrl_t ctrl);
    entry_t e;
    e.a    = a;
    e.b    = b;
    e.ctrl = ctrl;
    return e;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side and execute-side handshake bundle of the ID/EX stage
interface id_ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 2
);

  // Decode side.
  logic              InValid;
  logic              InReady;
  logic [15:0]       Instr;
  logic [DATA_W-1:0] RsData;
  logic [DATA_W-1:0] RtData;
  logic              Flush;

  // Execute side.
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] ExA;
  logic [DATA_W-1:0] ExB;
  logic [3:0]        ExShamt;
  logic [1:0]        ExFunct;
  logic [3:0]        ExOp;
  logic [REG_AW-1:0] ExRd;
  logic              ExRegWrite;
  logic              ExIsShift;

  // Environment view: drives the instruction stream and the execute-side ready.
  modport master (
    output InValid, Instr, RsData, RtData, Flush, OutReady,
    input  InReady, OutValid, ExA, ExB, ExShamt, ExFunct, ExOp, ExRd,
           ExRegWrite, ExIsShift
  );

  // Stage view.
  modport slave (
    input  InValid, Instr, RsData, RtData, Flush, OutReady,
    output InReady, OutValid, ExA, ExB, ExShamt, ExFunct, ExOp, ExRd,
           ExRegWrite, ExIsShift
  );

endinterface

// File: rtl/id_ex_stage_decode.sv
// rtl/id_ex_stage_decode.sv - combinational R-type field decode for the ID/EX stage
module id_ex_decode
  import cpu16_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output ctrl_t              o_ctrl
);

  logic [OPC_W-1:0]   w_op;
  logic [RD_W-1:0]    w_rd;
  logic [SHAMT_W-1:0] w_shamt;
  logic [FUNCT_W-1:0] w_funct;
  logic               w_unused_regaddr;

  assign w_op    = i_instr[OPC_LSB   +: OPC_W];
  assign w_rd    = i_instr[RD_LSB    +: RD_W];
  assign w_shamt = i_instr[SHAMT_LSB +: SHAMT_W];
  assign w_funct = i_instr[FUNCT_LSB +: FUNCT_W];

  // rs/rt address the register file upstream; only their read data reaches this stage.
  assign w_unused_regaddr = ^{i_instr[RS_LSB +: RS_W], i_instr[RT_LSB +: RT_W]};

  // Assemble control: R0 is hardwired zero, so a write to rd = 0 is suppressed here.
  always_comb begin
    o_ctrl          = '0;
    o_ctrl.op       = w_op;
    o_ctrl.rd       = w_rd;
    o_ctrl.shamt    = w_shamt;
    o_ctrl.funct    = w_funct;
    o_ctrl.isshift  = (w_op == OPC_RTYPE) && (w_funct == FUNCT_SLL);
    o_ctrl.regwrite = (w_op == OPC_RTYPE) && (w_rd != '0);
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - registered ID/EX stage with two-entry skid buffer toward the execute unit
module id_ex_stage
  import cpu16_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input logic          Clock,
  input logic          Reset,
  id_ex_stage_if.slave bus
);

  ctrl_t  w_ctrl;
  entry_t w_new_entry;
  entry_t r_main;
  entry_t r_skid;
  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;
  logic w_release;
  logic w_load_main;
  logic w_main_from_skid;
  logic w_load_skid;

  logic [DATA_W-1:0] w_ex_a;
  logic [DATA_W-1:0] w_ex_b;
  logic [REG_AW-1:0] w_ex_rd;

  id_ex_decode u_decode (
    .i_instr (bus.Instr),
    .o_ctrl  (w_ctrl)
  );

  assign w_new_entry = make_entry(bus.RsData, bus.RtData, w_ctrl);

  // Next occupancy and payload load enables; flush overrides every handshake.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_accept         = bus.InValid & (r_state != ST_FULL);
    w_release        = bus.OutReady & (r_state != ST_EMPTY);

    if (bus.Flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_main = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({w_accept, w_release})
            2'b10: begin
              w_load_skid = 1'b1;
              w_state_nxt = ST_FULL;
            end
            2'b01: begin
              w_state_nxt = ST_EMPTY;
            end
            2'b11: begin
              // Old main leaves this cycle, the new instruction takes its place.
              w_load_main = 1'b1;
            end
            default: begin
              w_state_nxt = ST_ONE;
            end
          endcase
        end
        ST_FULL: begin
          // InReady is low here, so only a release can happen.
          if (w_release) begin
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload registers; they hold while not enabled so a stalled bundle stays stable.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : w_new_entry;
      end
      if (w_load_skid) begin
        r_skid <= w_new_entry;
      end
    end
  end

  // Handshake flags depend only on the occupancy register.
  assign bus.OutValid = (r_state != ST_EMPTY);
  assign bus.InReady  = (r_state != ST_FULL);

  assign w_ex_a  = r_main.a;
  assign w_ex_b  = r_main.b;
  assign w_ex_rd = r_main.ctrl.rd;

  assign bus.ExA        = w_ex_a;
  assign bus.ExB        = w_ex_b;
  assign bus.ExShamt    = r_main.ctrl.shamt;
  assign bus.ExFunct    = r_main.ctrl.funct;
  assign bus.ExOp       = r_main.ctrl.op;
  assign bus.ExRd       = w_ex_rd;
  assign bus.ExRegWrite = r_main.ctrl.regwrite;
  assign bus.ExIsShift  = r_main.ctrl.isshift;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  id_ex_stage_if #(.DATA_W(16), .REG_AW(2)) bus ();

  id_ex_stage #(.DATA_W(16), .REG_AW(2)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  shamt;
    logic [1:0]  funct;
    logic [3:0]  op;
    logic [1:0]  rd;
    logic        rw;
    logic        sh;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  shamt;
    logic [1:0]  funct;
    logic [3:0]  op;
    logic [1:0]  rd;
    logic        rw;
    logic        sh;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   model_live = 0;
  exp_t q[$];
  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Field extraction by plain arithmetic on the instruction value.
  function automatic exp_t predict(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int   iv;
    iv      = int'(ins);
    r.a     = a;
    r.b     = b;
    r.op    = 4'(iv / 4096);
    r.rd    = 2'((iv / 64) % 4);
    r.shamt = 4'((iv / 4) % 16);
    r.funct = 2'(iv % 4);
    r.sh    = (r.op == 4'd0) && (r.funct == 2'd0);
    r.rw    = (r.op == 4'd0) && (r.rd != 2'd0);
    return r;
  endfunction

  function automatic exp_t got_bundle();
    exp_t g;
    g.a = bus.ExA; g.b = bus.ExB; g.shamt = bus.ExShamt; g.funct = bus.ExFunct;
    g.op = bus.ExOp; g.rd = bus.ExRd; g.rw = bus.ExRegWrite; g.sh = bus.ExIsShift;
    return g;
  endfunction

  // Reference: in-order queue of at most two bundles; front is what execute sees.
  task automatic model_check();
    if (model_live) begin
      chk("model_outvalid", bus.OutValid, q.size() != 0);
      chk("model_inready", bus.InReady, q.size() < 2);
      if (q.size() != 0) chk("model_bundle", got_bundle(), q[0]);
    end
  endtask

  task automatic model_update();
    int sz;
    sz = q.size();
    if (!Reset) begin
      q.delete();
      model_live = 1;
    end else if (bus.Flush) begin
      q.delete();
    end else begin
      if (sz > 0 && bus.OutReady) void'(q.pop_front());
      if (bus.InValid && sz < 2) q.push_back(predict(bus.Instr, bus.RsData, bus.RtData));
    end
  endtask

  // One clock: drive at negedge, compare, clock, update model, return at next negedge.
  task automatic cycle(input logic rstn, input logic v, input logic fl, input logic ordy,
                       input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
    Reset        = rstn;
    bus.InValid  = v;
    bus.Flush    = fl;
    bus.OutReady = ordy;
    bus.Instr    = ins;
    bus.RsData   = a;
    bus.RtData   = b;
    model_check();
    @(posedge Clock);
    model_update();
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 1, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{16'h0014, 16'h0003, 16'h1111, 4'd5,  2'd0, 4'h0, 2'd0, 1'b0, 1'b1};
    vt[1] = '{16'h0044, 16'hBEEF, 16'h2222, 4'd1,  2'd0, 4'h0, 2'd1, 1'b1, 1'b1};
    vt[2] = '{16'h00FF, 16'hFFFF, 16'h0000, 4'd15, 2'd3, 4'h0, 2'd3, 1'b1, 1'b0};
    vt[3] = '{16'h1040, 16'h1234, 16'h5678, 4'd0,  2'd0, 4'h1, 2'd1, 1'b0, 1'b0};
    vt[4] = '{16'hF0C3, 16'hA5A5, 16'h5A5A, 4'd0,  2'd3, 4'hF, 2'd3, 1'b0, 1'b0};
    vt[5] = '{16'h0F81, 16'h8000, 16'h0001, 4'd0,  2'd1, 4'h0, 2'd2, 1'b1, 1'b0};
    vt[6] = '{16'h003C, 16'h0F0F, 16'hF0F0, 4'd15, 2'd0, 4'h0, 2'd0, 1'b0, 1'b1};
    vt[7] = '{16'h80BE, 16'hCAFE, 16'hD00D, 4'd15, 2'd2, 4'h8, 2'd2, 1'b0, 1'b0};

    @(negedge Clock);

    // Reset held two cycles with garbage on the inputs.
    cycle(0, 1, 0, 1, 16'h0044, 16'h9999, 16'h7777);
    cycle(0, 1, 1, 0, 16'h00FF, 16'h8888, 16'h6666);
    chk("rst_outvalid", bus.OutValid, 1'b0);
    chk("rst_inready", bus.InReady, 1'b1);
    chk("rst_ex_zero", got_bundle(), 64'd0);
    idle(1);
    chk("rst_release_outvalid", bus.OutValid, 1'b0);
    chk("rst_release_ex_zero", got_bundle(), 64'd0);

    // Decode table, one instruction at a time from EMPTY.
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      cycle(1, 1, 0, 1, vt[i].ins, vt[i].a, vt[i].b);
      e = '{vt[i].a, vt[i].b, vt[i].shamt, vt[i].funct, vt[i].op, vt[i].rd, vt[i].rw, vt[i].sh};
      chk("vec_outvalid", bus.OutValid, 1'b1);
      chk("vec_bundle", got_bundle(), e);
      idle(1);
      chk("vec_drained", bus.OutValid, 1'b0);
    end

    // Back-to-back with OutReady high.
    for (int k = 1; k <= 4; k++) begin
      logic [15:0] ins;
      ins = 16'(64 + 4 * k);
      cycle(1, 1, 0, 1, ins, 16'(256 + k), 16'(512 + k));
      chk("b2b_outvalid", bus.OutValid, 1'b1);
      chk("b2b_shamt", bus.ExShamt, 4'(k));
      chk("b2b_regwrite", bus.ExRegWrite, 1'b1);
      chk("b2b_inready", bus.InReady, 1'b1);
    end
    idle(1);
    chk("b2b_done", bus.OutValid, 1'b0);

    // Stall: three instructions while OutReady is low.
    cycle(1, 1, 0, 0, 16'h0044, 16'hAAA1, 16'h0001);
    chk("stall_inready_one", bus.InReady, 1'b1);
    cycle(1, 1, 0, 0, 16'h0048, 16'hAAA2, 16'h0002);
    chk("stall_inready_full", bus.InReady, 1'b0);
    chk("stall_hold_a", bus.ExA, 16'hAAA1);
    cycle(1, 1, 0, 0, 16'h004C, 16'hAAA3, 16'h0003);
    chk("stall_still_full", bus.InReady, 1'b0);
    chk("stall_still_a", bus.ExA, 16'hAAA1);
    cycle(1, 1, 0, 1, 16'h004C, 16'hAAA3, 16'h0003);
    chk("stall_second_out", bus.ExA, 16'hAAA2);
    chk("stall_inready_back", bus.InReady, 1'b1);
    cycle(1, 1, 0, 1, 16'h004C, 16'hAAA3, 16'h0003);
    chk("stall_third_out", bus.ExA, 16'hAAA3);
    idle(1);
    chk("stall_drained", bus.OutValid, 1'b0);

    // Flush from FULL together with a new instruction.
    cycle(1, 1, 0, 0, 16'h0044, 16'hF001, 16'h0);
    cycle(1, 1, 0, 0, 16'h0048, 16'hF002, 16'h0);
    cycle(1, 1, 1, 0, 16'h004C, 16'hF003, 16'h0);
    chk("flush_outvalid", bus.OutValid, 1'b0);
    chk("flush_inready", bus.InReady, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("flush_nothing_emerges", bus.OutValid, 1'b0);
    end

    // Reset in the middle of a full buffer.
    cycle(1, 1, 0, 0, 16'h00C4, 16'hE001, 16'h1);
    cycle(1, 1, 0, 0, 16'h00C8, 16'hE002, 16'h2);
    cycle(0, 1, 0, 1, 16'h00CC, 16'hE003, 16'h3);
    chk("midrst_outvalid", bus.OutValid, 1'b0);
    chk("midrst_inready", bus.InReady, 1'b1);
    chk("midrst_ex_zero", got_bundle(), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("midrst_no_stale", bus.OutValid, 1'b0);
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ins;
      logic        rstn, fl, v, ordy;
      ins  = 16'($urandom);
      if ($urandom_range(0, 1) == 0) ins[15:12] = 4'h0;
      rstn = ($urandom_range(0, 63) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      cycle(rstn, v, fl, ordy, ins, 16'($urandom), 16'($urandom));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
